seq_unsigned_divider: RTL and testbench
=======================================

# seq_unsigned_divider

Multi-cycle restoring divider producing quotient and remainder of two unsigned operands, one quotient bit per clock. It is the inverse companion of the sequential unsigned multiplier and sits beside it in the processor's arithmetic hardware units. It shares the same start/done handshake, so the control unit sequences both identically.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only while idle
- dividend  input  WIDTH  unsigned dividend, captured at accepted start
- divisor  input  WIDTH  unsigned divisor, captured at accepted start
- quotient  output  WIDTH  result quotient, registered, held until next completion
- remainder  output  WIDTH  result remainder, registered, held until next completion
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: quotient/remainder just updated
- div_by_zero  output  1  divisor was zero for the completed operation; updated with done

## Operation
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, counter=0.
- FSM states: IDLE, RUN.
- IDLE: start=1 at an edge latches dividend into quotient shift register Q, divisor into D, clears partial remainder R (WIDTH+1 bits) and counter. Sets busy=1 and moves to RUN. start=0: stay.
- RUN, each edge, restoring step: S = {R[WIDTH-1:0], Q[WIDTH-1]}; T = S − {1'b0, D} (WIDTH+1 bits).
  - If T[WIDTH]=0: R←T, Q←{Q[WIDTH-2:0],1}.
  - Else: R←S, Q←{Q[WIDTH-2:0],0}.
  - Counter increments. On the WIDTH-th step, drive quotient←next Q and remainder←next R[WIDTH-1:0]. Pulse done=1, set busy=0 and return to IDLE.
- Final values satisfy dividend = quotient*divisor + remainder and remainder < divisor, for divisor≠0.
- Divisor 0 run through the loop yields quotient=all ones and remainder=dividend. This is the defined result in both build variants.
- start while busy=1 is ignored; operands are not re-sampled.
- Input changes after an accepted start have no effect on the running operation.
- rst mid-operation aborts immediately and returns to reset values; no done pulse.
- Within one module the restoring subtract is a plain ripple subtract; no library arithmetic IP.

## Timing
- Accepted start at edge N (busy rises after N). Step k occurs at edge N+k, for k=1..WIDTH.
- done=1 and results valid after edge N+WIDTH. Latency is WIDTH+1 edges (9 for WIDTH=8).
- done is high for exactly one cycle. busy falls at the same edge that done rises.
- start=1 in the done cycle is accepted at the next edge (N+WIDTH+1), giving back-to-back throughput of one operation per WIDTH+1 cycles. done falls at that edge.
- quotient/remainder/div_by_zero change only at the completion edge (or reset).

## Configuration
- SEQ_DIV_ZERO_CHECK_EN defined:
  - A start with divisor=0 skips RUN.
  - The next edge after acceptance completes: quotient=all ones, remainder=dividend, div_by_zero=1, done=1. Total latency is 2 edges.
  - div_by_zero=0 for every nonzero divisor.
- SEQ_DIV_ZERO_CHECK_EN undefined:
  - No early exit; divisor 0 takes the full WIDTH+1 latency and produces the same quotient/remainder.
  - div_by_zero is tied to 0.

## Test plan
- WIDTH=8, dividend=100, divisor=7, start one cycle → done exactly 9 edges after start edge, quotient=14, remainder=2, busy high for 8 cycles.
- Corner operands: 255/1 → q=255 r=0; 5/9 → q=0 r=5; 0/3 → q=0 r=0; 255/255 → q=1 r=0; 128/16 → q=8 r=0.
- Divisor 0, dividend=77: with macro → done after 2 edges, q=255, r=77, div_by_zero=1. Without macro → done after 9 edges, q=255, r=77, div_by_zero=0.
- 200/3 started, new start (50/5) pulsed at step 4 → ignored; result q=66 r=2. Then start held high in the done cycle → 50/5 accepted at next edge, q=10 r=0 after 9 more edges.
- rst asserted at step 5 of 100/7 → all outputs 0 immediately, no done pulse. Subsequent 9/2 → q=4 r=1.
- Randomised 1000 operand pairs, divisor≠0 → quotient*divisor+remainder==dividend and remainder<divisor for every done pulse.

Source files
------------

// File: rtl/seq_unsigned_divider.sv
// seq_unsigned_divider
// Multi-cycle restoring divider: one quotient bit per clock, start/done
// handshake shared with the sequential multiplier.
// Optional feature macro: SEQ_DIV_ZERO_CHECK_EN -- when defined, a zero
// divisor completes one edge after acceptance and raises div_by_zero;
// when undefined, a zero divisor runs the full loop and div_by_zero is 0.
module seq_unsigned_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder is always below the divisor after a step, so its
    // extra top bit is always zero and is not kept in the register.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_bit;

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor, keep the difference only when it did not borrow.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] r,
        input logic             in_bit,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] s;
        logic [WIDTH:0] t;
        s = {r, in_bit};
        t = s - {1'b0, d};
        if (!t[WIDTH]) begin
            restore_step = {t[WIDTH-1:0], 1'b1};
        end else begin
            restore_step = {s[WIDTH-1:0], 1'b0};
        end
    endfunction

    // Next partial remainder and next quotient shift register for this step.
    always_comb begin
        {r_nxt, q_bit} = restore_step(r_reg, q_sr[WIDTH-1], d_reg);
        q_nxt          = {q_sr[WIDTH-2:0], q_bit};
    end

`ifndef SEQ_DIV_ZERO_CHECK_EN
    assign div_by_zero = 1'b0;
`endif

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q_sr      <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_sr  <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    if (d_reg == '0) begin
                        // Early exit: same result the full loop would give.
                        quotient    <= '1;
                        remainder   <= q_sr;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else
`endif
                    begin
                        r_reg <= r_nxt;
                        q_sr  <= q_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            quotient  <= q_nxt;
                            remainder <= r_nxt;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                            div_by_zero <= 1'b0;
`endif
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// tb_seq_unsigned_divider
// Randomised and directed bench for seq_unsigned_divider (WIDTH=8), compared
// against a plain-arithmetic reference. Honours SEQ_DIV_ZERO_CHECK_EN.
module tb_seq_unsigned_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;
    int last_lat;
    int last_busy;

    seq_unsigned_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: ordinary integer division; zero divisor gives all ones / dividend.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
`ifdef SEQ_DIV_ZERO_CHECK_EN
        return (b == 0) ? 2 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic int ref_dz(input int b);
`ifdef SEQ_DIV_ZERO_CHECK_EN
        return (b == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Called at #1 after an accepting edge; counts edges (start edge = 1).
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                return;
            end
            if (busy) busy_cyc++;
        end
        chk("done_timeout", 0, 1);
    endtask

    // Called at #1 after an edge: present operands, pulse start for one edge,
    // then scramble the inputs so the running operation must ignore them.
    task automatic start_op(input int a, input int b);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic do_op(input string tag, input int a, input int b);
        start_op(a, b);
        chk({tag, "_busy_rise"}, busy, 1);
        wait_done(last_lat, last_busy);
        chk({tag, "_lat"}, last_lat, ref_lat(b));
        chk({tag, "_q"}, quotient, ref_q(a, b));
        chk({tag, "_r"}, remainder, ref_r(a, b));
        chk({tag, "_dz"}, div_by_zero, ref_dz(b));
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    int corner_a[5] = '{255, 5, 0, 255, 128};
    int corner_b[5] = '{1, 9, 3, 255, 16};

    initial begin
        int a, b, lat, bc;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic operation with busy duration
        do_op("b100_7", 100, 7);
        chk("b100_7_busy_cycles", last_busy, W);

        // Results held until the next completion
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", quotient, 14);
        chk("hold_r", remainder, 2);
        chk("hold_done", done, 0);

        // Corner operands
        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("corner%0d", i), corner_a[i], corner_b[i]);
        end

        // Divisor zero
        do_op("dz77", 77, 0);
        do_op("after_dz", 30, 4);

        // Start while busy is ignored, then back-to-back start in done cycle
        start_op(200, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'd1;
        divisor  = 8'd1;
        wait_done(lat, bc);
        chk("ign_lat", lat, 5);
        chk("ign_q", quotient, 66);
        chk("ign_r", remainder, 2);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        chk("b2b_done_fall", done, 0);
        chk("b2b_busy", busy, 1);
        wait_done(lat, bc);
        chk("b2b_lat", lat, W + 1);
        chk("b2b_q", quotient, 10);
        chk("b2b_r", remainder, 0);

        // Reset mid-operation
        start_op(100, 7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dz", div_by_zero, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("arst_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle_done", done, 0);
        end
        do_op("b9_2", 9, 2);

        // Randomised operands with nonzero divisor
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            do_op("rnd", a, b);
            chk("rnd_identity", int'(quotient) * b + int'(remainder), a);
            chk("rnd_r_lt_d", (int'(remainder) < b) ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
